// File: rtl/multdiv_unit.sv
// Multicycle signed multiply/divide unit for the execute stage.
// A one-cycle ctrl_MULT or ctrl_DIV pulse starts an operation. The unit runs WIDTH iterations
// and then raises data_resultRDY for one cycle with a registered result.
module multdiv_unit #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] data_operandA,
  input  logic [WIDTH-1:0] data_operandB,
  input  logic             ctrl_MULT,
  input  logic             ctrl_DIV,
  output logic [WIDTH-1:0] data_result,
  output logic             data_exception,
  output logic             data_resultRDY
);

  localparam logic [5:0]       LastCount = 6'(WIDTH);
  localparam logic [WIDTH-1:0] MinVal    = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [WIDTH-1:0] AllOnes   = {WIDTH{1'b1}};

  typedef enum logic [1:0] {StIdle, StMult, StDiv, StDone} state_e;

  state_e             state;
  logic [5:0]         count;
  logic [WIDTH-1:0]   a_q;
  logic [WIDTH-1:0]   b_q;
  // Booth product register: {upper, multiplier, extra bit}
  logic [2*WIDTH:0]   prod;
  logic [WIDTH-1:0]   rem;
  logic [WIDTH-1:0]   quo;
  logic [WIDTH-1:0]   div_mag;
  logic               neg;

  logic [WIDTH:0]     booth_sum;
  logic [2*WIDTH:0]   prod_next;
  logic [WIDTH:0]     div_shift;
  logic               div_ge;
  logic [WIDTH-1:0]   rem_next;
  logic [WIDTH-1:0]   quo_next;
  logic [WIDTH:0]     prod_top;
  logic               mult_ovf;

  function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] v);
    return v[WIDTH-1] ? (~v + 1'b1) : v;
  endfunction

  // Booth step: add/subtract in WIDTH+1 bits so the most negative multiplicand cannot overflow,
  // then shift the whole register right arithmetically by one.
  always_comb begin
    booth_sum = {prod[2*WIDTH], prod[2*WIDTH:WIDTH+1]};
    unique case (prod[1:0])
      2'b01:   booth_sum = booth_sum + {a_q[WIDTH-1], a_q};
      2'b10:   booth_sum = booth_sum - {a_q[WIDTH-1], a_q};
      default: booth_sum = booth_sum;
    endcase
    prod_next = {booth_sum, prod[WIDTH:1]};
    // Product is prod[2W:1]; overflow iff its bits [2W-1:W-1] are not a pure sign extension.
    prod_top  = prod[2*WIDTH:WIDTH];
    mult_ovf  = !((&prod_top) || (~|prod_top));
  end

  // Restoring division step on magnitudes: one quotient bit per iteration.
  always_comb begin
    div_shift = {rem, quo[WIDTH-1]};
    div_ge    = (div_shift >= {1'b0, div_mag});
    rem_next  = div_ge ? (div_shift[WIDTH-1:0] - div_mag) : div_shift[WIDTH-1:0];
    quo_next  = {quo[WIDTH-2:0], div_ge};
  end

  // Control FSM with registered outputs; a new start always preempts the current operation.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state          <= StIdle;
      count          <= '0;
      a_q            <= '0;
      b_q            <= '0;
      prod           <= '0;
      rem            <= '0;
      quo            <= '0;
      div_mag        <= '0;
      neg            <= 1'b0;
      data_result    <= '0;
      data_exception <= 1'b0;
      data_resultRDY <= 1'b0;
    end else begin
      data_resultRDY <= 1'b0;
      if (ctrl_MULT || ctrl_DIV) begin
        a_q     <= data_operandA;
        b_q     <= data_operandB;
        count   <= '0;
        prod    <= {{WIDTH{1'b0}}, data_operandB, 1'b0};
        rem     <= '0;
        quo     <= mag(data_operandA);
        div_mag <= mag(data_operandB);
        neg     <= data_operandA[WIDTH-1] ^ data_operandB[WIDTH-1];
        state   <= ctrl_MULT ? StMult : StDiv;
      end else begin
        unique case (state)
          StIdle: state <= StIdle;
          StMult: begin
            if (count == LastCount) begin
              data_result    <= prod[WIDTH:1];
              data_exception <= mult_ovf;
              data_resultRDY <= 1'b1;
              state          <= StDone;
            end else begin
              prod  <= prod_next;
              count <= count + 6'd1;
            end
          end
          StDiv: begin
            if (count == LastCount) begin
              if (div_mag == '0) begin
                data_result    <= '0;
                data_exception <= 1'b1;
              end else if (a_q == MinVal && b_q == AllOnes) begin
                data_result    <= MinVal;
                data_exception <= 1'b1;
              end else begin
                data_result    <= neg ? (~quo + 1'b1) : quo;
                data_exception <= 1'b0;
              end
              data_resultRDY <= 1'b1;
              state          <= StDone;
            end else begin
              rem   <= rem_next;
              quo   <= quo_next;
              count <= count + 6'd1;
            end
          end
          StDone:  state <= StIdle;
          default: state <= StIdle;
        endcase
      end
    end
  end

endmodule
